// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller slice.
//   pkg_alu   : ALU operation and A-operand select encodings.
//   pkg_reg   : register-file geometry and the hard-wired zero register.
//   pkg_issue : issue-side limits, the buffered instruction record and the
//               scoreboard pend entry.
package pkg_alu;
   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
   } op_t;
   typedef enum logic {ALU_REG = 1'b0, ALU_IMM = 1'b1} sel_t;
endpackage

package pkg_reg;
   localparam int REG_ADDRW = 5;
   localparam int REG_WIDTH = 32;
   localparam logic [REG_ADDRW-1:0] REG_ZERO = '0;
endpackage

package pkg_issue;
   import pkg_alu::*;
   import pkg_reg::*;

   localparam int ISSUE_LAT_MAX = 4;

   typedef struct packed {
      op_t                  op;
      sel_t                 a_sel;
      logic [REG_ADDRW-1:0] s_reg;
      logic [REG_ADDRW-1:0] b_reg;
      logic [REG_ADDRW-1:0] a_reg;
      logic [REG_WIDTH-1:0] a_imm;
   } instr_t;

   typedef struct packed {
      logic                 valid;
      logic [REG_ADDRW-1:0] addr;
   } pend_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// ALU instruction interface.
//   client : driven by the issue controller (op, a_sel, s_reg, b_reg, a_reg, a_imm)
//   server : sampled by the ALU datapath
interface if_instr_alu;
   import pkg_alu::*;
   import pkg_reg::*;

   op_t                  op;
   sel_t                 a_sel;
   logic [REG_ADDRW-1:0] s_reg;
   logic [REG_ADDRW-1:0] b_reg;
   logic [REG_ADDRW-1:0] a_reg;
   logic [REG_WIDTH-1:0] a_imm;

   modport client (output op, a_sel, s_reg, b_reg, a_reg, a_imm);
   modport server (input  op, a_sel, s_reg, b_reg, a_reg, a_imm);
endinterface

// File: rtl/alu_issue_ctrl_scoreboard.sv
// In-flight destination tracker.
//   clk, rst          : clock, synchronous active-high reset
//   issue             : the held instruction leaves for the ALU this cycle
//   s_reg             : destination of the held instruction
//   b_reg, a_reg,
//   a_sel             : sources of the held instruction (a_reg only when ALU_REG)
//   hazard            : a source matches an in-flight destination
//   wb_valid, wb_reg  : register-file write strobe, LAT cycles after issue
module alu_scoreboard
   import pkg_alu::*, pkg_reg::*, pkg_issue::*;
#(
   parameter int LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue,
   input  logic [REG_ADDRW-1:0] s_reg,
   input  logic [REG_ADDRW-1:0] b_reg,
   input  logic [REG_ADDRW-1:0] a_reg,
   input  sel_t                 a_sel,
   output logic                 hazard,
   output logic                 wb_valid,
   output logic [REG_ADDRW-1:0] wb_reg
);

   pend_t pend [LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) pend[k] <= '0;
      end else begin
         // Register 0 is hard-wired, so its writes are never tracked.
         pend[0].valid <= issue && (s_reg != REG_ZERO);
         pend[0].addr  <= s_reg;
         for (int k = 1; k < LAT; k++) pend[k] <= pend[k-1];
      end
   end

   // The last stage is included: the register file has no write-through,
   // so a value being written this cycle is not yet readable.
   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < LAT; k++) begin
         if (pend[k].valid &&
             ((b_reg != REG_ZERO && pend[k].addr == b_reg) ||
              (a_sel == ALU_REG && a_reg != REG_ZERO && pend[k].addr == a_reg)))
            hazard = 1'b1;
      end
   end

   // Gated by rst so the cycle in which reset is first seen drops the strobe.
   assign wb_valid = pend[LAT-1].valid && !rst;
   assign wb_reg   = pend[LAT-1].addr;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller between the decoder and the ALU datapath.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready + in_*      : decoded instruction handshake
//   flush                         : drop the held, not yet issued instruction
//   alu (client), alu_valid       : instruction presented to the ALU
//   wb_valid, wb_reg              : register-file write strobe/address
//   stall_cnt                     : saturating count of hazard-stalled cycles
// LAT is legal in 1..ISSUE_LAT_MAX.
module alu_issue_ctrl
   import pkg_alu::*, pkg_reg::*, pkg_issue::*;
#(
   parameter int LAT        = 2,
   parameter int STALL_CNTW = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  op_t                   in_op,
   input  sel_t                  in_a_sel,
   input  logic [REG_ADDRW-1:0]  in_s_reg,
   input  logic [REG_ADDRW-1:0]  in_b_reg,
   input  logic [REG_ADDRW-1:0]  in_a_reg,
   input  logic [REG_WIDTH-1:0]  in_a_imm,
   input  logic                  flush,
   if_instr_alu.client           alu,
   output logic                  alu_valid,
   output logic                  wb_valid,
   output logic [REG_ADDRW-1:0]  wb_reg,
   output logic [STALL_CNTW-1:0] stall_cnt
);

   logic   hold_valid;
   instr_t hold;
   logic   hazard;
   logic   issue;
   logic   accept;

   assign issue    = hold_valid && !hazard && !flush && !rst;
   // An issuing slot can be refilled in the same cycle, so the stream runs
   // at one instruction per cycle without bubbles.
   assign in_ready = !rst && (!hold_valid || issue);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst)                  hold_valid <= 1'b0;
      else if (accept)          hold_valid <= 1'b1;
      else if (issue || flush)  hold_valid <= 1'b0;
   end

   // Payload is don't-care while hold_valid is low, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept)
         hold <= '{op: in_op, a_sel: in_a_sel, s_reg: in_s_reg,
                   b_reg: in_b_reg, a_reg: in_a_reg, a_imm: in_a_imm};
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (hold_valid && hazard && !flush && stall_cnt != '1)
         stall_cnt <= stall_cnt + STALL_CNTW'(1);
   end

   assign alu.op    = hold.op;
   assign alu.a_sel = hold.a_sel;
   assign alu.s_reg = hold.s_reg;
   assign alu.b_reg = hold.b_reg;
   assign alu.a_reg = hold.a_reg;
   assign alu.a_imm = hold.a_imm;
   assign alu_valid = issue;

   alu_scoreboard #(.LAT(LAT)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .issue    (issue),
      .s_reg    (hold.s_reg),
      .b_reg    (hold.b_reg),
      .a_reg    (hold.a_reg),
      .a_sel    (hold.a_sel),
      .hazard   (hazard),
      .wb_valid (wb_valid),
      .wb_reg   (wb_reg)
   );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
   import pkg_alu::*;
   import pkg_reg::*;
   import pkg_issue::*;

   localparam int LAT = 2;
   localparam int SCW = 4;
   localparam int SMAX = (1 << SCW) - 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   op_t                  in_op = ALU_ADD;
   sel_t                 in_a_sel = ALU_REG;
   logic [REG_ADDRW-1:0] in_s_reg = '0, in_b_reg = '0, in_a_reg = '0;
   logic [REG_WIDTH-1:0] in_a_imm = '0;
   logic                 flush = 1'b0;
   logic                 alu_valid, wb_valid;
   logic [REG_ADDRW-1:0] wb_reg;
   logic [SCW-1:0]       stall_cnt;

   int checks = 0;
   int errors = 0;

   if_instr_alu alu_if ();

   alu_issue_ctrl #(.LAT(LAT), .STALL_CNTW(SCW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a_sel(in_a_sel), .in_s_reg(in_s_reg),
      .in_b_reg(in_b_reg), .in_a_reg(in_a_reg), .in_a_imm(in_a_imm),
      .flush(flush), .alu(alu_if), .alu_valid(alu_valid),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model (timestamp based) ----------------
   int     mcyc;
   int     busy_until [32];   // cycle of the pending writeback per register
   int     wb_at [int];       // cycle -> register written in that cycle
   logic   m_hv;
   instr_t m_h;
   int     m_stall;
   logic   e_ready, e_issue, e_hz, e_wb;
   int     e_wb_reg;

   function automatic logic busy(input logic [REG_ADDRW-1:0] r);
      return (r != 0) && (mcyc <= busy_until[r]);
   endfunction

   function automatic void model_reset();
      mcyc = 0; m_hv = 1'b0; m_stall = 0;
      for (int r = 0; r < 32; r++) busy_until[r] = -1;
      wb_at.delete();
   endfunction

   function automatic void model_eval();
      e_hz    = m_hv && (busy(m_h.b_reg) || (m_h.a_sel == ALU_REG && busy(m_h.a_reg)));
      e_issue = !rst && m_hv && !e_hz && !flush;
      e_ready = !rst && (!m_hv || e_issue);
      e_wb    = !rst && wb_at.exists(mcyc);
      e_wb_reg = e_wb ? wb_at[mcyc] : 0;
   endfunction

   function automatic void model_commit();
      if (rst) begin
         model_reset();
         return;
      end
      if (e_issue && m_h.s_reg != 0) begin
         busy_until[m_h.s_reg] = mcyc + LAT;
         wb_at[mcyc + LAT] = int'(m_h.s_reg);
      end
      if (m_hv && e_hz && !flush && m_stall < SMAX) m_stall++;
      if (in_valid && e_ready) begin
         m_hv = 1'b1;
         m_h = '{op: in_op, a_sel: in_a_sel, s_reg: in_s_reg, b_reg: in_b_reg,
                 a_reg: in_a_reg, a_imm: in_a_imm};
      end else if (e_issue || flush) m_hv = 1'b0;
      if (wb_at.exists(mcyc)) wb_at.delete(mcyc);
      mcyc++;
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic offer(input int s, input int b, input int a, input sel_t sel);
      in_valid = 1'b1; in_op = ALU_ADD; in_a_sel = sel;
      in_s_reg = REG_ADDRW'(s); in_b_reg = REG_ADDRW'(b); in_a_reg = REG_ADDRW'(a);
      in_a_imm = 32'h1234_0000 | 32'(s);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      tick(); tick();
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || alu_valid !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b alu_valid=%b wb_valid=%b required 0/0/0",
                     in_ready, alu_valid, wb_valid);
         end
         tick();
      end
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (stall_cnt !== '0 || in_ready !== 1'b1 || wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: stall_cnt=%0d in_ready=%b wb_valid=%b required 0/1/0",
                  stall_cnt, in_ready, wb_valid);
      end
      tick();
   endtask

   task automatic test_independent();
      logic [2:0] ev [6];      // {in_ready, alu_valid, wb_valid} per cycle
      int         exp_s [6];
      int         exp_w [6];
      do_reset();
      ev = '{3'b100, 3'b110, 3'b110, 3'b101, 3'b101, 3'b100};
      exp_s = '{0, 3, 6, 0, 0, 0};
      exp_w = '{0, 0, 0, 3, 6, 0};
      for (int c = 0; c < 6; c++) begin
         if (c == 0) offer(3, 1, 2, ALU_REG);
         else if (c == 1) offer(6, 4, 5, ALU_REG);
         else idle();
         @(negedge clk);
         checks++;
         if ({in_ready, alu_valid, wb_valid} !== ev[c] ||
             (alu_valid && alu_if.s_reg !== REG_ADDRW'(exp_s[c])) ||
             (wb_valid && wb_reg !== REG_ADDRW'(exp_w[c])) || stall_cnt !== '0) begin
            errors++;
            $display("FAIL independent_c%0d: rdy/alu/wb=%b s_reg=%0d wb_reg=%0d stall=%0d required %b/%0d/%0d/0",
                     c, {in_ready, alu_valid, wb_valid}, alu_if.s_reg, wb_reg, stall_cnt,
                     ev[c], exp_s[c], exp_w[c]);
         end
         tick();
      end
   endtask

   task automatic test_raw_b();
      do_reset();
      offer(3, 1, 2, ALU_REG); tick();          // first held, issues next cycle (t)
      offer(4, 3, 1, ALU_REG); tick();          // t: first issues, second accepted
      idle();
      for (int c = 1; c <= 3; c++) begin        // t+1 .. t+3
         @(negedge clk);
         checks++;
         if (alu_valid !== (c == 3) || (c == 3 && alu_if.s_reg !== 5'd4) ||
             wb_valid !== (c == 2)) begin
            errors++;
            $display("FAIL raw_b_t+%0d: alu_valid=%b s_reg=%0d wb_valid=%b required alu=%b wb=%b",
                     c, alu_valid, alu_if.s_reg, wb_valid, c == 3, c == 2);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (stall_cnt !== 4'd2) begin
         errors++;
         $display("FAIL raw_b_stall: stall_cnt=%0d required 2", stall_cnt);
      end
   endtask

   task automatic test_raw_a();
      for (int m = 0; m < 2; m++) begin
         sel_t sel;
         int   issue_at;
         sel = (m == 0) ? ALU_REG : ALU_IMM;
         issue_at = (m == 0) ? 3 : 1;
         do_reset();
         offer(3, 1, 2, ALU_REG); tick();
         offer(4, 1, 3, sel); tick();
         idle();
         for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (alu_valid !== (c == issue_at)) begin
               errors++;
               $display("FAIL raw_a_sel%0d_t+%0d: alu_valid=%b required %b",
                        m, c, alu_valid, c == issue_at);
            end
            tick();
         end
         @(negedge clk);
         checks++;
         if (stall_cnt !== SCW'(m == 0 ? 2 : 0)) begin
            errors++;
            $display("FAIL raw_a_sel%0d_stall: stall_cnt=%0d required %0d",
                     m, stall_cnt, m == 0 ? 2 : 0);
         end
      end
   endtask

   task automatic test_reg0();
      do_reset();
      offer(0, 1, 2, ALU_REG); tick();
      offer(7, 0, 0, ALU_REG); tick();          // t
      idle();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if (alu_valid !== (c == 1) || wb_valid !== (c == 3) ||
             (c == 3 && wb_reg !== 5'd7)) begin
            errors++;
            $display("FAIL reg0_t+%0d: alu_valid=%b wb_valid=%b wb_reg=%0d required alu=%b wb=%b",
                     c, alu_valid, wb_valid, wb_reg, c == 1, c == 3);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      do_reset();
      offer(3, 1, 2, ALU_REG); tick();
      offer(4, 3, 1, ALU_REG); tick();          // t: hazarded second held
      idle(); flush = 1'b1;                     // t+1
      @(negedge clk);
      checks++;
      if (alu_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_t+1: alu_valid=%b in_ready=%b required 0/0", alu_valid, in_ready);
      end
      tick();
      offer(5, 0, 0, ALU_IMM);                  // t+2: flush with hold empty, still accepts
      @(negedge clk);
      checks++;
      if (alu_valid !== 1'b0 || in_ready !== 1'b1 || wb_valid !== 1'b1 ||
          wb_reg !== 5'd3 || stall_cnt !== '0) begin
         errors++;
         $display("FAIL flush_t+2: alu=%b rdy=%b wb=%b wb_reg=%0d stall=%0d required 0/1/1/3/0",
                  alu_valid, in_ready, wb_valid, wb_reg, stall_cnt);
      end
      tick();
      idle(); flush = 1'b0;                     // t+3
      @(negedge clk);
      checks++;
      if (alu_valid !== 1'b1 || alu_if.s_reg !== 5'd5 || wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_t+3: alu=%b s_reg=%0d wb=%b required 1/5/0",
                  alu_valid, alu_if.s_reg, wb_valid);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      offer(3, 1, 2, ALU_REG); tick();
      offer(4, 3, 1, ALU_REG); tick();          // t
      idle(); tick();                           // t+1: stalled once
      rst = 1'b1;                               // t+2: writeback of %3 would be here
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || wb_valid !== 1'b0 || alu_valid !== 1'b0 ||
             (c == 2 && stall_cnt !== 4'd1)) begin
            errors++;
            $display("FAIL rstmid_t+%0d: rdy=%b wb=%b alu=%b stall=%0d required 0/0/0 stall=%0d",
                     c, in_ready, wb_valid, alu_valid, stall_cnt, c == 2 ? 1 : 0);
         end
         tick();
      end
      rst = 1'b0;
      for (int c = 4; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || wb_valid !== 1'b0 || alu_valid !== 1'b0 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL rstmid_t+%0d: rdy=%b wb=%b alu=%b stall=%0d required 1/0/0/0",
                     c, in_ready, wb_valid, alu_valid, stall_cnt);
         end
         tick();
      end
   endtask

   // Ten-link dependency chain: 9 links x 2 stalls exceeds the 4-bit counter.
   task automatic test_stall_sat();
      int acc = 0, iss = 0, cyc = 0;
      do_reset();
      offer(3, 3, 0, ALU_IMM);
      while (iss < 10 && cyc < 100) begin
         @(negedge clk);
         if (alu_valid) iss++;
         if (in_valid && in_ready) acc++;
         tick();
         if (acc == 10) idle();
         cyc++;
      end
      checks++;
      if (iss != 10) begin
         errors++;
         $display("FAIL stall_sat_issues: issued=%0d within %0d cycles required 10", iss, cyc);
      end
      @(negedge clk);
      checks++;
      if (stall_cnt !== 4'(SMAX)) begin
         errors++;
         $display("FAIL stall_sat: stall_cnt=%0d required %0d", stall_cnt, SMAX);
      end
      tick();
   endtask

   task automatic test_random();
      instr_t act;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_op    = op_t'($urandom_range(0, 7));
         in_a_sel = sel_t'($urandom_range(0, 1));
         in_s_reg = REG_ADDRW'($urandom_range(0, 7));
         in_b_reg = REG_ADDRW'($urandom_range(0, 7));
         in_a_reg = REG_ADDRW'($urandom_range(0, 7));
         in_a_imm = $urandom;
         flush    = ($urandom_range(0, 19) == 0);
         rst      = ($urandom_range(0, 49) == 0);
         @(negedge clk);
         model_eval();
         act = '{op: alu_if.op, a_sel: alu_if.a_sel, s_reg: alu_if.s_reg,
                 b_reg: alu_if.b_reg, a_reg: alu_if.a_reg, a_imm: alu_if.a_imm};
         checks++;
         if (in_ready !== e_ready || alu_valid !== e_issue || wb_valid !== e_wb ||
             (e_wb && wb_reg !== REG_ADDRW'(e_wb_reg)) ||
             (e_issue && act !== m_h) || stall_cnt !== SCW'(m_stall)) begin
            errors++;
            $display("FAIL random_c%0d: rdy=%b alu=%b wb=%b wb_reg=%0d stall=%0d s=%0d required %b/%b/%b/%0d/%0d s=%0d",
                     c, in_ready, alu_valid, wb_valid, wb_reg, stall_cnt, act.s_reg,
                     e_ready, e_issue, e_wb, e_wb_reg, m_stall, m_h.s_reg);
         end
         @(posedge clk);
         model_commit();
         #1;
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_independent();
      test_raw_b();
      test_raw_a();
      test_reg0();
      test_flush();
      test_reset_mid();
      test_stall_sat();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
